// File: rtl/jk_cmd_driver_if.sv
// Command handshake bundle between an upstream op source and jk_cmd_driver.
// The master presents cmd_valid/cmd_op; the slave answers with cmd_ready.
interface jk_cmd_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: sequences 2-bit JK ops into a downstream jk_ff and checks
// the read-back q against a shadow model. Flow: IDLE -> DRIVE -> SETTLE -> CHECK.
// Optional macro JK_QBAR_CHECK_EN: also flag a mismatch when qbar_in is not ~q_in.
module jk_cmd_driver #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_cmd_driver_if.slave       cmd,
    output logic                 j,
    output logic                 k,
    input  logic                 q_in,
    input  logic                 qbar_in,
    output logic                 done,
    output logic                 q_sampled,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     op_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck
    } state_e;

    localparam logic [3:0]       SettleLast = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             done_q, done_d;
    logic             mm_q, mm_d;
    logic             qs_q, qs_d;
    logic             exp_q, exp_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             nxt_exp;
    logic             chk_fail;

    // Shadow model: expected q after the latched op has been applied.
    always_comb begin
        nxt_exp = exp_q;
        unique case (op_q)
            2'b00:   nxt_exp = exp_q;
            2'b01:   nxt_exp = 1'b0;
            2'b10:   nxt_exp = 1'b1;
            2'b11:   nxt_exp = ~exp_q;
            default: nxt_exp = exp_q;
        endcase
    end

`ifdef JK_QBAR_CHECK_EN
    // Complementary-output check folded into the same mismatch flag.
    assign chk_fail = (q_in != nxt_exp) || (qbar_in == q_in);
`else
    // qbar_in kept on the port list for a stable interface only.
    logic unused_qbar;
    assign unused_qbar = qbar_in;
    assign chk_fail    = (q_in != nxt_exp);
`endif

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        j_d       = 1'b0;
        k_d       = 1'b0;
        done_d    = 1'b0;
        mm_d      = 1'b0;
        qs_d      = qs_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            StIdle: begin
                // cmd_ready is high in this state, so valid alone is an accept.
                if (cmd.cmd_valid) begin
                    op_d    = cmd.cmd_op;
                    j_d     = cmd.cmd_op[1];
                    k_d     = cmd.cmd_op[0];
                    state_d = StDrive;
                end
            end
            StDrive: begin
                cnt_d   = 4'd0;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    // Sample at the edge entering CHECK so done/mismatch/q_sampled
                    // and the counters are all visible together during CHECK.
                    state_d  = StCheck;
                    cnt_d    = 4'd0;
                    done_d   = 1'b1;
                    mm_d     = chk_fail;
                    qs_d     = q_in;
                    exp_d    = q_in;  // resync so one fault yields one mismatch
                    op_cnt_d = (op_cnt_q == CntMax) ? op_cnt_q : op_cnt_q + CNT_W'(1);
                    if (chk_fail) begin
                        err_cnt_d = (err_cnt_q == CntMax) ? err_cnt_q
                                                          : err_cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCheck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset that overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 2'b00;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            done_q    <= 1'b0;
            mm_q      <= 1'b0;
            qs_q      <= 1'b0;
            exp_q     <= 1'b0;
            cnt_q     <= 4'd0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            j_q       <= j_d;
            k_q       <= k_d;
            done_q    <= done_d;
            mm_q      <= mm_d;
            qs_q      <= qs_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cmd.cmd_ready = (state_q == StIdle);
    assign j             = j_q;
    assign k             = k_q;
    assign done          = done_q;
    assign mismatch      = mm_q;
    assign q_sampled     = qs_q;
    assign op_cnt        = op_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver: main instance (SETTLE_CYC=1, CNT_W=8) driving a
// behavioural jk_ff, plus a saturation instance (SETTLE_CYC=2, CNT_W=2).
module tb_jk_cmd_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- main instance ----------------
    jk_cmd_driver_if bus ();
    logic       j, k, done, q_sampled, mismatch;
    logic [7:0] op_cnt, err_cnt;
    logic       ff_q;
    logic       force_q   = 1'b0;
    logic       force_val = 1'b0;
    logic       qbar_ovr  = 1'b0;
    logic       q_in_m, qbar_in_m;

    assign q_in_m    = force_q ? force_val : ff_q;
    assign qbar_in_m = qbar_ovr ? q_in_m : ~q_in_m;

    // Reference jk_ff sharing the driver's reset.
    always @(posedge clk) begin
        if (rst) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    jk_cmd_driver #(.SETTLE_CYC(1), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (bus.slave),
        .j         (j),
        .k         (k),
        .q_in      (q_in_m),
        .qbar_in   (qbar_in_m),
        .done      (done),
        .q_sampled (q_sampled),
        .mismatch  (mismatch),
        .op_cnt    (op_cnt),
        .err_cnt   (err_cnt)
    );

    // ---------------- saturation instance ----------------
    jk_cmd_driver_if sbus ();
    logic       s_j, s_k, s_done, s_qs, s_mm;
    logic [1:0] s_op_cnt, s_err_cnt;
    logic       s_q = 1'b0;
    logic       s_qbar;
    assign s_qbar = ~s_q;

    jk_cmd_driver #(.SETTLE_CYC(2), .CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .cmd       (sbus.slave),
        .j         (s_j),
        .k         (s_k),
        .q_in      (s_q),
        .qbar_in   (s_qbar),
        .done      (s_done),
        .q_sampled (s_qs),
        .mismatch  (s_mm),
        .op_cnt    (s_op_cnt),
        .err_cnt   (s_err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op on the main instance; checks each cycle of the 4-cycle flow.
    task automatic do_op(input logic [1:0] op, input logic exp_qs, input logic exp_mm);
        check_eq("ready_before_accept", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        step();                                 // DRIVE
        bus.cmd_valid = 1'b0;
        check_eq("drive_jk", {30'd0, j, k}, {30'd0, op});
        check_eq("drive_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check_eq("drive_done", {31'd0, done}, 32'd0);
        step();                                 // SETTLE
        check_eq("settle_jk", {30'd0, j, k}, 32'd0);
        check_eq("settle_done", {31'd0, done}, 32'd0);
        step();                                 // CHECK
        check_eq("check_done", {31'd0, done}, 32'd1);
        check_eq("check_qs", {31'd0, q_sampled}, {31'd0, exp_qs});
        check_eq("check_mm", {31'd0, mismatch}, {31'd0, exp_mm});
        check_eq("check_jk", {30'd0, j, k}, 32'd0);
        step();                                 // IDLE
        check_eq("idle_done", {31'd0, done}, 32'd0);
        check_eq("idle_mm", {31'd0, mismatch}, 32'd0);
    endtask

    // One set op on the saturation instance (q held wrong at 0).
    task automatic do_sat_op(input logic [1:0] exp_ops, input logic [1:0] exp_errs);
        sbus.cmd_valid = 1'b1;
        sbus.cmd_op    = 2'b10;
        step();                                 // DRIVE
        sbus.cmd_valid = 1'b0;
        check_eq("sat_drive_j", {31'd0, s_j}, 32'd1);
        step();                                 // SETTLE 1
        check_eq("sat_settle1_done", {31'd0, s_done}, 32'd0);
        step();                                 // SETTLE 2
        check_eq("sat_settle2_done", {31'd0, s_done}, 32'd0);
        step();                                 // CHECK
        check_eq("sat_done", {31'd0, s_done}, 32'd1);
        check_eq("sat_mm", {31'd0, s_mm}, 32'd1);
        check_eq("sat_qs", {31'd0, s_qs}, 32'd0);
        check_eq("sat_op_cnt", {30'd0, s_op_cnt}, {30'd0, exp_ops});
        check_eq("sat_err_cnt", {30'd0, s_err_cnt}, {30'd0, exp_errs});
        step();                                 // IDLE
    endtask

    logic [1:0] bp_tbl [20];
    int         acc_cyc [8];
    int         n_acc;
    logic       pend;
    logic [1:0] pend_op;

    initial begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'b10;
        sbus.cmd_valid = 1'b0;
        sbus.cmd_op    = 2'b00;

        // Reset held 2 cycles with cmd_valid high: nothing accepted.
        rst = 1'b1;
        step();
        step();
        check_eq("rst_jk", {30'd0, j, k}, 32'd0);
        check_eq("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_op_cnt", {24'd0, op_cnt}, 32'd0);
        check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check_eq("rst_qs", {31'd0, q_sampled}, 32'd0);
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        step();
        check_eq("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Functional sequence against the real flop.
        do_op(2'b10, 1'b1, 1'b0);
        do_op(2'b11, 1'b0, 1'b0);
        do_op(2'b11, 1'b1, 1'b0);
        do_op(2'b00, 1'b1, 1'b0);
        do_op(2'b01, 1'b0, 1'b0);
        check_eq("func_op_cnt", {24'd0, op_cnt}, 32'd5);
        check_eq("func_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Fault: q stuck at 0, set expects 1 -> one mismatch, then resync.
        force_q   = 1'b1;
        force_val = 1'b0;
        do_op(2'b10, 1'b0, 1'b1);
        check_eq("fault_err_cnt", {24'd0, err_cnt}, 32'd1);
        do_op(2'b00, 1'b0, 1'b0);
        check_eq("resync_err_cnt", {24'd0, err_cnt}, 32'd1);
        force_q = 1'b0;
        // Real flop holds 1 while shadow is 0; a reset op realigns both.
        do_op(2'b01, 1'b0, 1'b0);
        check_eq("fault_op_cnt", {24'd0, op_cnt}, 32'd8);

        // Backpressure: valid held 20 cycles, op changing every cycle.
        for (int i = 0; i < 20; i++) bp_tbl[i] = 2'(i * 3 + 1);
        bp_tbl[0]  = 2'b10;
        bp_tbl[4]  = 2'b11;
        bp_tbl[8]  = 2'b01;
        bp_tbl[12] = 2'b11;
        bp_tbl[16] = 2'b10;
        n_acc = 0;
        pend  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = bp_tbl[i];
            if (bus.cmd_ready) begin
                if (n_acc < 8) acc_cyc[n_acc] = i;
                n_acc++;
                pend    = 1'b1;
                pend_op = bp_tbl[i];
            end
            step();
            if (pend) begin
                check_eq("bp_drive_jk", {30'd0, j, k}, {30'd0, pend_op});
                pend = 1'b0;
            end
            check_eq("bp_no_mm", {31'd0, mismatch}, 32'd0);
        end
        bus.cmd_valid = 1'b0;
        check_eq("bp_accepts", n_acc, 32'd5);
        for (int a = 0; a < 5; a++) check_eq("bp_accept_cycle", acc_cyc[a], a * 4);
        check_eq("bp_op_cnt", {24'd0, op_cnt}, 32'd13);
        check_eq("bp_qs", {31'd0, q_sampled}, 32'd1);

        // qbar equal to a correct q: only the complementary check can flag it.
        qbar_ovr = 1'b1;
`ifdef JK_QBAR_CHECK_EN
        do_op(2'b10, 1'b1, 1'b1);
        check_eq("qbar_err_cnt", {24'd0, err_cnt}, 32'd2);
`else
        do_op(2'b10, 1'b1, 1'b0);
        check_eq("qbar_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
        qbar_ovr = 1'b0;

        // Reset during SETTLE: abort, back to IDLE, no done.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        step();                                 // DRIVE
        bus.cmd_valid = 1'b0;
        step();                                 // SETTLE
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check_eq("abort_jk", {30'd0, j, k}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        step();
        check_eq("abort_no_late_done", {31'd0, done}, 32'd0);
        // Reset clears the counters; the aborted op must not add to them.
        check_eq("abort_op_cnt", {24'd0, op_cnt}, 32'd0);
        do_op(2'b10, 1'b1, 1'b0);
        check_eq("post_abort_op_cnt", {24'd0, op_cnt}, 32'd1);

        // Saturation: CNT_W=2, five wrong results.
        do_sat_op(2'd1, 2'd1);
        do_sat_op(2'd2, 2'd2);
        do_sat_op(2'd3, 2'd3);
        do_sat_op(2'd3, 2'd3);
        do_sat_op(2'd3, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jk_cmd_driver.md
Name: jk_cmd_driver

Overview:
- Command sequencer that sits directly upstream of the jk_ff storage cell.
- Accepts 2-bit JK operations over a valid/ready handshake and drives the cell's j/k inputs for exactly one clock.
- Reads back q/qbar from the cell and checks the result against an internal shadow model.
- Reports a per-op done/mismatch pulse and maintains saturating op and error counters.

Parameters:
- SETTLE_CYC, 1, cycles to wait after the j/k drive cycle before sampling q_in. Legal range 1..15.
- CNT_W, 8, width of op_cnt and err_cnt.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset. Shared with the downstream jk_ff.
- cmd_valid  input  1  command present.
- cmd_op  input  2  operation: 00 hold, 01 reset (j0 k1), 10 set (j1 k0), 11 toggle (j1 k1).
- cmd_ready  output  1  block can accept a command.
- j  output  1  registered J drive to jk_ff.
- k  output  1  registered K drive to jk_ff.
- q_in  input  1  q from jk_ff.
- qbar_in  input  1  qbar from jk_ff.
- done  output  1  one-cycle pulse: check complete.
- q_sampled  output  1  q_in value captured at CHECK; held until the next CHECK.
- mismatch  output  1  one-cycle pulse, coincident with done, when the check fails.
- op_cnt  output  CNT_W  completed ops; saturates at all-ones.
- err_cnt  output  CNT_W  mismatching ops; saturates at all-ones.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - On rst: state=IDLE, j=0, k=0, cmd_ready=1, done=0, mismatch=0, q_sampled=0, exp_q=0, op_cnt=0, err_cnt=0, settle counter=0.
- State machine: IDLE -> DRIVE -> SETTLE -> CHECK -> IDLE.
- IDLE:
  - cmd_ready=1 (combinational from state). j=k=0.
  - On cmd_valid & cmd_ready: latch cmd_op and go to DRIVE.
  - Compute nxt_exp from the latched op: hold=exp_q, reset=0, set=1, toggle=~exp_q.
- DRIVE (exactly 1 cycle):
  - j/k registered from the latched op. They are high only during this cycle, so jk_ff samples them at the edge ending DRIVE.
  - Hold drives j=k=0.
  - cmd_ready=0.
- SETTLE:
  - j=k=0. Counter runs SETTLE_CYC cycles, then goes to CHECK.
- CHECK (1 cycle):
  - done=1; q_sampled<=q_in.
  - mismatch=1 iff q_in != nxt_exp.
  - op_cnt increments, saturating. err_cnt increments on mismatch, saturating.
  - exp_q<=q_in in all cases (self-resync), so a single fault gives a single mismatch.
  - Return to IDLE.
- Latency:
  - Accept in cycle 0, j/k valid in cycle 1, done in cycle 2+SETTLE_CYC, cmd_ready high again the following cycle.
  - With SETTLE_CYC=1: one op per 4 cycles.
- Handshake:
  - Upstream holds cmd_op stable while cmd_valid & !cmd_ready.
  - cmd_valid outside IDLE is ignored; no queuing.
  - cmd_valid held high continuously gives back-to-back ops at the max rate.
- Reset mid-operation:
  - rst in any state wins over all transitions.
  - Next cycle is IDLE with j=k=0.
  - No done for the aborted op; the counters are not incremented.
- Simultaneous events:
  - rst together with cmd_valid: the command is dropped.
  - Counter saturation and mismatch in the same cycle: err_cnt holds at max and mismatch still pulses.

Optional Feature:
- Macro: JK_QBAR_CHECK_EN.
- Defined: CHECK also flags mismatch when qbar_in != ~q_in (complementary-output check); it counts in err_cnt like any other mismatch.
- Undefined: qbar_in is unused (port kept for a stable interface), and mismatch depends on q_in only.

Test Plan:
- Reset: rst=1 for 2 cycles with cmd_valid=1 -> j=k=0, cmd_ready=1, done=0, op_cnt=err_cnt=0; no command accepted.
- Functional sequence, real jk_ff attached, SETTLE_CYC=1: ops 10,11,11,00,01 -> q_sampled 1,0,1,1,0; mismatch never asserts; op_cnt=5; j/k each high exactly 1 cycle per op; done 3 cycles after each accept.
- Fault injection: q_in forced 0, op 10 -> mismatch=1, err_cnt=1, q_sampled=0; then op 00 -> mismatch=0 (resync), err_cnt stays 1.
- Backpressure: cmd_valid held 1 for 20 cycles with cmd_op changing every cycle -> exactly 5 accepts, at cycles 0,4,8,12,16; each executes the op present at its accept cycle.
- Reset mid-op: rst pulsed during SETTLE of an op 10 -> next cycle IDLE, no done pulse, op_cnt unchanged, j=k=0.
- Saturation plus macro: CNT_W=2, 5 ops with q_in forced wrong -> op_cnt=3, err_cnt=3. With JK_QBAR_CHECK_EN defined and qbar_in tied equal to a correct q_in, op 10 -> mismatch=1; undefined -> mismatch=0.
